axi_user_master: RTL and testbench

- Bridges the simple cache-side "AXI USER" request interface (start/rw/addr/len, per-beat wdata/rdata strobes, done/busy) onto a single AXI4 master port.
- Sits directly downstream of the D-cache; the I-cache can use a second instance.
- Issues one INCR burst per request and holds exactly one transaction outstanding.
- Reports per-beat read data, write-beat acceptance, completion and response errors back to the cache.

---
 rtl/axi_defs_pkg.sv | 30 +++
 rtl/axi_user_master.sv | 166 ++++++++++++++++
 tb/tb_axi_user_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_defs_pkg.sv
// Shared AXI4 constants, FSM state encoding and burst-length helper for the
// cache-side AXI user masters.
package axi_defs_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // A zero length still moves one beat; anything past the cap is truncated.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    if (len == 8'd0) return 8'd1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/axi_user_master.sv
// Cache-side request bridge onto one AXI4 master port: one INCR burst per
// request, a single transaction outstanding, per-beat strobes back to the cache.
module axi_user_master
  import axi_defs_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                axi_start,
  input  logic                axi_rw,
  input  logic [ADDR_W-1:0]   axi_addr,
  input  logic [7:0]          axi_len,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic                axi_rvalid,
  output logic                axi_done,
  output logic                axi_busy,
  output logic                axi_err,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [7:0]          cnt;
  logic                aw_done, w_done, err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                last_cnt;

  // Beat counter is shared by R and W: only one direction is active at a time.
  assign last_cnt = (cnt == len_q - 8'd1);

  assign m_araddr  = addr_q;
  assign m_awaddr  = addr_q;
  assign m_arlen   = len_q - 8'd1;
  assign m_awlen   = len_q - 8'd1;
  assign m_arsize  = AXI_SIZE_4B;
  assign m_awsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;
  assign m_awburst = AXI_BURST_INCR;
  assign m_wstrb   = '1;
  assign m_wdata   = axi_wdata;
  assign axi_rdata  = rdata_q;
  assign axi_rvalid = rvalid_q;
  assign axi_busy   = (state != ST_IDLE);
  assign axi_wready = m_wready && m_wvalid;

  // Next-state and channel handshake outputs.
  always_comb begin
    state_nx  = state;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    axi_done  = 1'b0;
    axi_err   = 1'b0;
    case (state)
      ST_IDLE: if (axi_start) state_nx = axi_rw ? ST_AR : ST_WR;
      ST_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nx = ST_R;
      end
      ST_R: begin
        m_rready = 1'b1;
        if (m_rvalid && (m_rlast || last_cnt)) state_nx = ST_DONE;
      end
      ST_WR: begin
        // AW and W run independently; leave only once both have finished.
        m_awvalid = !aw_done;
        m_wvalid  = axi_wvalid && !w_done;
        m_wlast   = last_cnt;
        if ((aw_done || m_awready) && (w_done || (axi_wvalid && m_wready && last_cnt)))
          state_nx = ST_B;
      end
      ST_B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_nx = ST_DONE;
      end
      ST_DONE: begin
        axi_done = 1'b1;
        axi_err  = err_q;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register, request latch, beat counting and sticky error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= 8'd1;
      cnt      <= 8'd0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_nx;
      rvalid_q <= 1'b0;
      case (state)
        ST_IDLE: if (axi_start) begin
          addr_q  <= axi_addr;
          len_q   <= clamp_len(axi_len, MAX_LEN8);
          cnt     <= 8'd0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          err_q   <= 1'b0;
        end
        ST_R: if (m_rvalid) begin
          rdata_q  <= m_rdata;
          rvalid_q <= 1'b1;
          cnt      <= cnt + 8'd1;
          if (m_rresp != AXI_RESP_OKAY) err_q <= 1'b1;
        end
        ST_WR: begin
          if (!aw_done && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready) begin
            cnt <= cnt + 8'd1;
            if (last_cnt) w_done <= 1'b1;
          end
        end
        ST_B: if (m_bvalid && (m_bresp != AXI_RESP_OKAY)) err_q <= 1'b1;
        ST_DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_user_master.sv
// Bench for axi_user_master: behavioural AXI slave with programmable delays,
// a cache-side write-beat source, and per-transaction expectations derived
// from the request (clamped length, data sent, responses returned).
module tb_axi_user_master;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        axi_start = 1'b0, axi_rw = 1'b0;
  logic [31:0] axi_addr = '0;
  logic [7:0]  axi_len = '0;
  logic [31:0] axi_wdata = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready, axi_rvalid, axi_done, axi_busy, axi_err;
  logic [31:0] axi_rdata;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst;
  logic        m_arvalid, m_rready, m_awvalid, m_wlast, m_wvalid, m_bready;
  logic [3:0]  m_wstrb;
  logic        m_arready = 1'b0, m_rlast = 1'b0, m_rvalid = 1'b0;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0, m_bresp = '0;

  axi_user_master dut (
    .clk(clk), .resetn(resetn), .axi_start(axi_start), .axi_rw(axi_rw),
    .axi_addr(axi_addr), .axi_len(axi_len), .axi_wdata(axi_wdata),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_rdata(axi_rdata),
    .axi_rvalid(axi_rvalid), .axi_done(axi_done), .axi_busy(axi_busy), .axi_err(axi_err),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // slave / cache-source configuration
  int ar_delay, aw_delay, w_stall, b_delay, gap_pct;
  logic [1:0]  bresp_val;
  logic [31:0] r_q[$], cw_q[$];
  logic [1:0]  rresp_q[$];
  bit          cw_active;
  // slave progress
  int ar_wait, aw_wait, w_wait, b_wait, r_left, r_idx, w_idx;
  bit r_hold, b_sent;
  // observations
  int n_ar, n_aw, n_wlast, done_cnt, rv_at_done, bad_wready, early_done, fld_bad;
  logic [31:0] ar_addr_s, aw_addr_s;
  logic [7:0]  ar_len_s, aw_len_s;
  logic [31:0] rd_got[$], w_got[$];
  bit          wl_got[$];
  bit          err_seen;

  // Inputs change on the falling edge; everything is observed 1 time unit later.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      m_arready = 0; m_rvalid = 0; m_rlast = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      m_rdata = 0; m_rresp = 0; m_bresp = 0; axi_wvalid = 0; axi_wdata = 0;
      r_left = 0; r_hold = 0; ar_wait = 0; aw_wait = 0;
    end else begin
      m_arready = m_arvalid && (ar_wait >= ar_delay);
      m_awready = m_awvalid && (aw_wait >= aw_delay);
      m_wready  = (w_wait >= w_stall) && ($urandom_range(99) >= gap_pct);
      if (!r_hold) begin
        if (r_left > 0 && $urandom_range(99) >= gap_pct) begin
          m_rvalid = 1;
          m_rdata  = (r_idx < r_q.size()) ? r_q[r_idx] : 32'h0;
          m_rresp  = (r_idx < rresp_q.size()) ? rresp_q[r_idx] : 2'b00;
          m_rlast  = (r_left == 1);
        end else begin
          m_rvalid = 0; m_rlast = 0;
        end
      end
      m_bvalid   = (n_aw > 0) && (n_wlast > 0) && !b_sent && (b_wait >= b_delay);
      m_bresp    = bresp_val;
      axi_wvalid = cw_active && (w_idx < cw_q.size());
      axi_wdata  = axi_wvalid ? cw_q[w_idx] : 32'h0;
    end
    #1;
    if (m_arvalid && m_arready) begin
      n_ar++; ar_addr_s = m_araddr; ar_len_s = m_arlen; r_left = int'(m_arlen) + 1; ar_wait = 0;
      if (m_arsize !== 3'b010 || m_arburst !== 2'b01) fld_bad++;
    end else if (m_arvalid) ar_wait++;
    if (m_awvalid && m_awready) begin
      n_aw++; aw_addr_s = m_awaddr; aw_len_s = m_awlen; aw_wait = 0;
      if (m_awsize !== 3'b010 || m_awburst !== 2'b01) fld_bad++;
    end else if (m_awvalid) aw_wait++;
    r_hold = m_rvalid && !m_rready;
    if (m_rvalid && m_rready) begin r_idx++; r_left--; end
    if (m_wvalid && m_wready) begin
      w_got.push_back(m_wdata); wl_got.push_back(m_wlast);
      if (m_wlast) n_wlast++;
      if (m_wstrb !== 4'hF) fld_bad++;
    end
    if (axi_wready !== (m_wvalid && m_wready)) bad_wready++;
    if (axi_wready) w_idx++;
    if (axi_busy) w_wait++;
    if (m_bvalid && m_bready) b_sent = 1;
    else if (n_aw > 0 && n_wlast > 0 && !b_sent) b_wait++;
    if (axi_rvalid) rd_got.push_back(axi_rdata);
    if (axi_done) begin
      done_cnt++; err_seen = axi_err; rv_at_done = rd_got.size();
      if (n_aw > 0 && !b_sent) early_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Configure the slave and build the expected data for one request.
  task automatic setup(input bit rw, input int len, input int ard, input int awd, input int wst,
                       input int bd, input int gap, input logic [1:0] bresp,
                       input logic [15:0] rerr, input logic [31:0] dbase,
                       output int eff, output bit exp_err);
    logic [31:0] d;
    eff = (len == 0) ? 1 : (len > 16 ? 16 : len);
    ar_delay = ard; aw_delay = awd; w_stall = wst; b_delay = bd; gap_pct = gap; bresp_val = bresp;
    ar_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0; r_idx = 0; w_idx = 0; b_sent = 0;
    n_ar = 0; n_aw = 0; n_wlast = 0; done_cnt = 0; rv_at_done = 0;
    bad_wready = 0; early_done = 0; fld_bad = 0; err_seen = 0;
    r_q.delete(); rresp_q.delete(); cw_q.delete(); rd_got.delete(); w_got.delete(); wl_got.delete();
    exp_err = rw ? 1'b0 : (bresp != 2'b00);
    for (int i = 0; i < eff; i++) begin
      d = (dbase != 0) ? (rw ? dbase * (i + 1) : dbase + i) : $urandom;
      r_q.push_back(d); cw_q.push_back(d);
      rresp_q.push_back(rerr[i] ? ((i % 2) ? 2'b10 : 2'b11) : 2'b00);
      if (rw && rerr[i]) exp_err = 1;
    end
    cw_active = !rw;
  endtask

  task automatic do_txn(input bit rw, input logic [31:0] addr, input int len, input int ard,
                        input int awd, input int wst, input int bd, input int gap,
                        input logic [1:0] bresp, input logic [15:0] rerr, input logic [31:0] dbase);
    int eff, t;
    bit exp_err;
    setup(rw, len, ard, awd, wst, bd, gap, bresp, rerr, dbase, eff, exp_err);
    axi_rw = rw; axi_addr = addr; axi_len = 8'(len); axi_start = 1;
    @(posedge clk); #1 axi_start = 0;
    @(negedge clk); #2;
    checks++; if (axi_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", axi_busy); end
    t = 0;
    while (done_cnt == 0 && t < 400) begin @(negedge clk); #2; t++; end
    checks++; if (done_cnt == 0) begin errors++; $display("FAIL done_timeout rw=%0d len=%0d got no done want done", rw, len); end
    checks++; if ((rw ? n_ar : n_aw) != 1) begin errors++; $display("FAIL addr_handshakes got %0d want 1", rw ? n_ar : n_aw); end
    checks++; if ((rw ? n_aw : n_ar) != 0) begin errors++; $display("FAIL wrong_channel got %0d want 0", rw ? n_aw : n_ar); end
    checks++; if ((rw ? ar_len_s : aw_len_s) !== 8'(eff - 1)) begin errors++; $display("FAIL axlen got %0d want %0d", rw ? ar_len_s : aw_len_s, eff - 1); end
    checks++; if ((rw ? ar_addr_s : aw_addr_s) !== addr) begin errors++; $display("FAIL axaddr got %h want %h", rw ? ar_addr_s : aw_addr_s, addr); end
    checks++; if (fld_bad != 0) begin errors++; $display("FAIL fixed_fields got %0d bad want 0", fld_bad); end
    checks++; if (err_seen !== exp_err) begin errors++; $display("FAIL err got %b want %b", err_seen, exp_err); end
    if (rw) begin
      checks++; if (rd_got.size() != eff) begin errors++; $display("FAIL rvalid_count got %0d want %0d", rd_got.size(), eff); end
      for (int i = 0; i < eff && i < rd_got.size(); i++) begin
        checks++; if (rd_got[i] !== r_q[i]) begin errors++; $display("FAIL rdata[%0d] got %h want %h", i, rd_got[i], r_q[i]); end
      end
      checks++; if (rv_at_done != eff) begin errors++; $display("FAIL last_rvalid_with_done got %0d want %0d", rv_at_done, eff); end
    end else begin
      checks++; if (w_got.size() != eff) begin errors++; $display("FAIL w_beats got %0d want %0d", w_got.size(), eff); end
      for (int i = 0; i < eff && i < w_got.size(); i++) begin
        checks++; if (w_got[i] !== cw_q[i] || wl_got[i] !== (i == eff - 1)) begin
          errors++; $display("FAIL wbeat[%0d] got %h/%b want %h/%b", i, w_got[i], wl_got[i], cw_q[i], i == eff - 1); end
      end
      checks++; if (early_done != 0) begin errors++; $display("FAIL done_before_b got %0d want 0", early_done); end
      checks++; if (bad_wready != 0) begin errors++; $display("FAIL wready_rule got %0d bad want 0", bad_wready); end
    end
    @(negedge clk); #2;
    checks++; if (axi_busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b want 0", axi_busy); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_count got %0d want 1", done_cnt); end
    cw_active = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({axi_busy, axi_done, axi_err, axi_rvalid, axi_wready, m_arvalid, m_rready,
         m_awvalid, m_wvalid, m_wlast, m_bready} !== 11'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {axi_busy, axi_done, axi_err, axi_rvalid,
        axi_wready, m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready});
    end
    resetn = 1;
    @(negedge clk); #2;
  endtask

  task automatic test_read_burst();
    do_txn(1, 32'h1C00_0040, 4, 2, 0, 0, 0, 0, 2'b00, 16'h0, 32'd11);
  endtask

  task automatic test_write_aw_slow();
    do_txn(0, 32'h1C00_0104, 1, 0, 3, 0, 0, 0, 2'b00, 16'h0, 32'hDEAD_BEEF);
  endtask

  task automatic test_write_w_stall();
    do_txn(0, 32'h1C00_0200, 4, 0, 0, 4, 2, 0, 2'b00, 16'h0, 32'h0);
  endtask

  task automatic test_err_resp();
    do_txn(1, 32'h1C00_0300, 2, 0, 0, 0, 0, 0, 2'b00, 16'b10, 32'h0);
    do_txn(1, 32'h1C00_0380, 2, 0, 0, 0, 0, 0, 2'b00, 16'h0, 32'h0);
    do_txn(0, 32'h1C00_0400, 3, 1, 0, 0, 1, 0, 2'b10, 16'h0, 32'h0);
    do_txn(0, 32'h1C00_0480, 3, 0, 0, 0, 0, 0, 2'b00, 16'h0, 32'h0);
  endtask

  task automatic test_start_busy();
    int eff, t;
    bit exp_err;
    setup(1, 8, 1, 0, 0, 0, 40, 2'b00, 16'h0, 32'h0, eff, exp_err);
    axi_rw = 1; axi_addr = 32'h1C00_0500; axi_len = 8'd8; axi_start = 1;
    @(posedge clk); #1 axi_start = 0;
    t = 0;
    while (n_ar == 0 && t < 50) begin @(negedge clk); #2; t++; end
    axi_addr = 32'h1C00_0900; axi_start = 1;
    @(posedge clk); #1 axi_start = 0;
    t = 0;
    while (done_cnt == 0 && t < 400) begin @(negedge clk); #2; t++; end
    repeat (10) @(negedge clk);
    #2;
    checks++; if (n_ar != 1) begin errors++; $display("FAIL busy_start_ar got %0d want 1", n_ar); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", done_cnt); end
    checks++; if (ar_addr_s !== 32'h1C00_0500) begin errors++; $display("FAIL busy_start_addr got %h want 1c000500", ar_addr_s); end
    checks++; if (rd_got.size() != 8) begin errors++; $display("FAIL busy_start_beats got %0d want 8", rd_got.size()); end
  endtask

  task automatic test_reset_mid();
    int eff, t;
    bit exp_err;
    setup(1, 4, 0, 0, 0, 0, 0, 2'b00, 16'h0, 32'h0, eff, exp_err);
    axi_rw = 1; axi_addr = 32'h1C00_0600; axi_len = 8'd4; axi_start = 1;
    @(posedge clk); #1 axi_start = 0;
    t = 0;
    while (rd_got.size() < 2 && t < 50) begin @(negedge clk); #2; t++; end
    checks++; if (rd_got.size() < 2) begin errors++; $display("FAIL reset_mid_beats got %0d want 2", rd_got.size()); end
    resetn = 0;
    @(negedge clk); #2;
    checks++;
    if ({axi_busy, axi_done, axi_err, axi_rvalid, axi_wready, m_arvalid, m_rready,
         m_awvalid, m_wvalid, m_wlast, m_bready} !== 11'b0) begin
      errors++; $display("FAIL reset_mid_outputs got %b want 0", {axi_busy, axi_done, axi_err, axi_rvalid,
        axi_wready, m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready});
    end
    resetn = 1;
    @(negedge clk); #2;
    do_txn(1, 32'h1C00_0700, 4, 0, 0, 0, 0, 0, 2'b00, 16'h0, 32'h0);
  endtask

  task automatic test_len_edges();
    do_txn(1, 32'h1C00_0800, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0, 32'h0);
    do_txn(0, 32'h1C00_0840, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0, 32'h0);
    do_txn(1, 32'h1C00_0880, 16, 0, 0, 0, 0, 0, 2'b00, 16'h0, 32'h0);
    do_txn(1, 32'h1C00_08C0, 200, 0, 0, 0, 0, 0, 2'b00, 16'h0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      do_txn($urandom_range(1), $urandom & 32'hFFFF_FFFC, $urandom_range(20),
             $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3),
             $urandom_range(40), ($urandom_range(5) == 0) ? 2'b10 : 2'b00,
             16'($urandom) & 16'($urandom) & 16'($urandom), 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_aw_slow();
    test_write_w_stall();
    test_err_resp();
    test_start_busy();
    test_reset_mid();
    test_len_edges();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
